// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM width decoder.
//
// Contents:
//   state_e            - measurement FSM encoding (IDLE / HIGH / LOW)
//   WIDTH_DEFAULT      - default counter/output width, matches the width word W
//   MAX_COUNT_DEFAULT  - default counter saturation value
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam int unsigned WIDTH_DEFAULT     = 13;
  localparam int unsigned MAX_COUNT_DEFAULT = 8191;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer and edge detector for an asynchronous single-wire input.
//
// Parameters:
//   SYNC_STAGES - number of synchronizer flops (must be at least 2)
// Ports:
//   clk   in   core clock
//   reset in   asynchronous active-low reset
//   d     in   asynchronous input
//   s     out  synchronized level
//   rise  out  one-cycle pulse, s went 0 -> 1
//   fall  out  one-cycle pulse, s went 1 -> 0
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/pwm_width_decoder.sv
// PWM width decoder: measures high time and period of a PWM line in clk cycles.
//
// Parameters:
//   WIDTH       - counter and output width
//   SYNC_STAGES - synchronizer depth on signal_in (>= 2)
//   MAX_COUNT   - counter saturation value (<= 2**WIDTH-1)
// Ports:
//   clk       in   core clock
//   reset     in   asynchronous active-low reset
//   en        in   measurement enable
//   signal_in in   asynchronous PWM input
//   W_meas    out  last measured high time
//   P_meas    out  last measured period (rise to rise), clamped at MAX_COUNT
//   valid     out  one-cycle strobe when W_meas/P_meas update
//   timeout   out  sticky: line stuck for MAX_COUNT cycles; cleared by a report
//   busy      out  FSM is in HIGH or LOW
module pwm_width_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_COUNT   = MAX_COUNT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             signal_in,
  output logic [WIDTH-1:0] W_meas,
  output logic [WIDTH-1:0] P_meas,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);

  // Counters stop at MAX_COUNT instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == MAX_C) ? v : v + WIDTH'(1);
  endfunction

  // Period sum is formed one bit wider, then clamped to MAX_COUNT.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > MAX_EXT) ? MAX_C : sum[WIDTH-1:0];
  endfunction

  logic s, rise, fall;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .reset(reset),
    .d    (signal_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] lcnt_q, lcnt_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      w_q       <= '0;
      p_q       <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      w_q       <= w_d;
      p_q       <= p_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    w_d       = w_q;
    p_d       = p_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!en) begin
      // Dropping enable discards any partial measurement; results are held.
      state_d = IDLE;
      hcnt_d  = '0;
      lcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          hcnt_d = '0;
          lcnt_d = '0;
          if (rise) begin
            state_d = HIGH;
            hcnt_d  = WIDTH'(1);
          end
        end

        HIGH: begin
          // An edge on the saturation cycle takes priority over timeout.
          if (fall) begin
            state_d = LOW;
            lcnt_d  = WIDTH'(1);
          end else if (hcnt_q == MAX_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            hcnt_d    = '0;
            lcnt_d    = '0;
          end else begin
            hcnt_d = sat_inc(hcnt_q);
          end
        end

        LOW: begin
          if (rise) begin
            // Report the completed period and immediately start the next one.
            w_d       = hcnt_q;
            p_d       = sat_sum(hcnt_q, lcnt_q);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            state_d   = HIGH;
            hcnt_d    = WIDTH'(1);
            lcnt_d    = '0;
          end else if (lcnt_q == MAX_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            hcnt_d    = '0;
            lcnt_d    = '0;
          end else begin
            lcnt_d = sat_inc(lcnt_q);
          end
        end

        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
          lcnt_d  = '0;
        end
      endcase
    end
  end

  assign W_meas  = w_q;
  assign P_meas  = p_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q == HIGH) || (state_q == LOW);

endmodule

// File: tb/tb_pwm_width_decoder.sv
// Self-checking bench for pwm_width_decoder. Expected reports (W, P and the
// cycle valid must appear on) are queued when the completing rise is driven
// and popped when the DUT raises valid.
module tb_pwm_width_decoder;

  localparam int WIDTH = 13;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             signal_in = 1'b0;
  logic [WIDTH-1:0] W_meas;
  logic [WIDTH-1:0] P_meas;
  logic             valid;
  logic             timeout;
  logic             busy;

  pwm_width_decoder #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .MAX_COUNT  (8191)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .signal_in(signal_in),
    .W_meas   (W_meas),
    .P_meas   (P_meas),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int p;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: every valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid cyc=%0d got W=%0d P=%0d, no report expected",
                   cyc, W_meas, P_meas);
        end else begin
          e = exp_q.pop_front();
          if (W_meas !== 13'(e.w) || P_meas !== 13'(e.p) || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL report got W=%0d P=%0d at cyc %0d, expected W=%0d P=%0d at cyc %0d",
                     W_meas, P_meas, cyc, e.w, e.p, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One period starting with a rise now. If rep, that rise completes a
  // previous period reported as (ew, ep), valid 3 cycles later.
  task automatic drive_period(input int h, input int l, input bit rep,
                              input int ew, input int ep);
    exp_t e;
    signal_in = 1'b1;
    if (rep) begin
      e.w = ew; e.p = ep; e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    wait_cycles(h);
    signal_in = 1'b0;
    wait_cycles(l);
  endtask

  task automatic start_test();
    signal_in = 1'b0;
    en = 1'b1;
    wait_cycles(2);
  endtask

  task automatic end_test(input string name);
    signal_in = 1'b0;
    wait_cycles(5);
    en = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_reports_missing got %0d outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_after_disable got %b, expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (W_meas !== '0 || P_meas !== '0 || valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got W=%0d P=%0d v=%b to=%b busy=%b, expected all 0",
               W_meas, P_meas, valid, timeout, busy);
    end
    reset = 1'b1;
    wait_cycles(2);
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle got busy=%b valid=%b, expected 0/0", busy, valid);
    end
  endtask

  task automatic test_nominal();
    start_test();
    drive_period(100, 150, 1'b0, 0, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_busy got %b, expected 1", busy);
    end
    for (int i = 0; i < 3; i++) drive_period(100, 150, 1'b1, 100, 250);
    end_test("nominal");
    n_checks++;
    if (W_meas !== 13'd100 || P_meas !== 13'd250) begin
      n_fail++;
      $display("FAIL nominal_hold got W=%0d P=%0d, expected 100/250", W_meas, P_meas);
    end
  endtask

  task automatic test_duty_change();
    start_test();
    drive_period(100, 150, 1'b0, 0, 0);
    drive_period(100, 150, 1'b1, 100, 250);
    drive_period(200, 50, 1'b1, 100, 250);
    drive_period(200, 50, 1'b1, 200, 250);
    drive_period(200, 50, 1'b1, 200, 250);
    end_test("duty");
    n_checks++;
    if (W_meas !== 13'd200 || P_meas !== 13'd250) begin
      n_fail++;
      $display("FAIL duty_hold got W=%0d P=%0d, expected 200/250", W_meas, P_meas);
    end
  endtask

  task automatic test_stuck_high();
    exp_t e;
    start_test();
    drive_period(100, 150, 1'b0, 0, 0);
    drive_period(100, 150, 1'b1, 100, 250);
    signal_in = 1'b1;
    e.w = 100; e.p = 250; e.cyc = cyc + 3;
    exp_q.push_back(e);
    // hcnt reaches 8191 in the cycle after posedge rise+8193; timeout lands one edge later.
    wait_cycles(8193);
    n_checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_pre_sat got timeout=%b busy=%b, expected 0/1", timeout, busy);
    end
    wait_cycles(1);
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_timeout got %b, expected 1", timeout);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_idle got busy=%b, expected 0", busy);
    end
    n_checks++;
    if (W_meas !== 13'd100 || P_meas !== 13'd250) begin
      n_fail++;
      $display("FAIL stuck_held got W=%0d P=%0d, expected 100/250", W_meas, P_meas);
    end
    wait_cycles(9000 - 8194);
    signal_in = 1'b0;
    wait_cycles(150);
    drive_period(100, 150, 1'b0, 0, 0);
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_sticky got %b, expected 1", timeout);
    end
    drive_period(100, 150, 1'b1, 100, 250);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_recover_clear got %b, expected 0", timeout);
    end
    end_test("stuck");
  endtask

  task automatic test_enable_drop();
    exp_t e;
    start_test();
    drive_period(80, 120, 1'b0, 0, 0);
    drive_period(80, 120, 1'b1, 80, 200);
    signal_in = 1'b1;
    e.w = 80; e.p = 200; e.cyc = cyc + 3;
    exp_q.push_back(e);
    wait_cycles(40);
    en = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_busy got %b, expected 0", busy);
    end
    wait_cycles(27);
    en = 1'b1;
    wait_cycles(30);
    signal_in = 1'b0;
    wait_cycles(120);
    n_checks++;
    if (W_meas !== 13'd80 || P_meas !== 13'd200 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_hold got W=%0d P=%0d busy=%b, expected 80/200/0",
               W_meas, P_meas, busy);
    end
    drive_period(100, 150, 1'b0, 0, 0);
    n_checks++;
    if (W_meas !== 13'd80 || P_meas !== 13'd200) begin
      n_fail++;
      $display("FAIL endrop_rearm_hold got W=%0d P=%0d, expected 80/200", W_meas, P_meas);
    end
    drive_period(100, 150, 1'b1, 100, 250);
    end_test("endrop");
  endtask

  task automatic test_async_reset();
    exp_t e;
    start_test();
    drive_period(100, 150, 1'b0, 0, 0);
    drive_period(100, 150, 1'b1, 100, 250);
    signal_in = 1'b1;
    e.w = 100; e.p = 250; e.cyc = cyc + 3;
    exp_q.push_back(e);
    wait_cycles(100);
    signal_in = 1'b0;
    wait_cycles(50);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (W_meas !== '0 || P_meas !== '0 || valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outputs got W=%0d P=%0d v=%b to=%b busy=%b, expected all 0",
               W_meas, P_meas, valid, timeout, busy);
    end
    #26 reset = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(100);
    drive_period(100, 150, 1'b0, 0, 0);
    n_checks++;
    if (W_meas !== '0 || P_meas !== '0) begin
      n_fail++;
      $display("FAIL areset_first_rise got W=%0d P=%0d, expected 0/0", W_meas, P_meas);
    end
    drive_period(100, 150, 1'b1, 100, 250);
    end_test("areset");
  endtask

  task automatic test_saturation();
    exp_t e;
    start_test();
    drive_period(10, 10, 1'b0, 0, 0);
    drive_period(8191, 10, 1'b1, 10, 20);
    signal_in = 1'b1;
    e.w = 8191; e.p = 8191; e.cyc = cyc + 3;
    exp_q.push_back(e);
    wait_cycles(10);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_no_timeout got %b, expected 0", timeout);
    end
    n_checks++;
    if (W_meas !== 13'd8191 || P_meas !== 13'd8191) begin
      n_fail++;
      $display("FAIL sat_values got W=%0d P=%0d, expected 8191/8191", W_meas, P_meas);
    end
    end_test("sat");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_duty_change();
    test_stuck_high();
    test_enable_drop();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
